// File: rtl/placar_pkg.sv
// Shared constants and helpers for the scoreboard accumulator.
package placar_pkg;

    localparam int unsigned PONTOS_A       = 1;
    localparam int unsigned PONTOS_B       = 2;
    localparam int unsigned PONTOS_C       = 3;

    localparam int unsigned MAX_PONTOS_DEF = 99;
    localparam int unsigned BUZ_CICLOS_DEF = 25000000;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/detector_borda.sv
// Two-flop synchronizer followed by a single-cycle rising-edge pulse.
module detector_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic borda_c
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s2d_q, s2d_d;

    // Next state of the synchronizer chain and the edge-history flop.
    always_comb begin
        s1_d  = btn;
        s2_d  = s1_q;
        s2d_d = s2_q;
    end

    // Synchronizer and edge-history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            s2d_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s2d_q <= s2d_d;
        end
    end

    assign borda_c = s2_q & ~s2d_q;

endmodule

// File: rtl/placar_acumulador.sv
// Registered team scoreboard: button presses add/subtract 1/2/3 points on the
// selected team, with saturation, underflow rejection and a timed buzzer.
// Optional undo feature enabled by defining PLACAR_DESFAZER_EN.
module placar_acumulador
    import placar_pkg::*;
#(
    parameter  int unsigned N_TIMES    = 2,
    parameter  int unsigned PW         = 7,
    parameter  int unsigned MAX_PONTOS = MAX_PONTOS_DEF,
    parameter  int unsigned BUZ_CICLOS = BUZ_CICLOS_DEF,
    localparam int unsigned TW         = clog2(N_TIMES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_a,
    input  logic                  btn_b,
    input  logic                  btn_c,
`ifdef PLACAR_DESFAZER_EN
    input  logic                  btn_desfazer,
`endif
    input  logic                  modo_sub,
    input  logic [TW-1:0]         time_sel,
    input  logic                  zerar,
    output logic [N_TIMES*PW-1:0] pontos,
    output logic                  valido,
    output logic                  erro,
    output logic                  buzina
);

    localparam int unsigned  CW       = clog2(BUZ_CICLOS + 1);
    localparam logic [PW:0]  MAX_EXT  = (PW+1)'(MAX_PONTOS);
    localparam logic [CW-1:0] BUZ_LOAD = CW'(BUZ_CICLOS);
    localparam logic [1:0]   INC_A    = 2'(PONTOS_A);
    localparam logic [1:0]   INC_B    = 2'(PONTOS_B);
    localparam logic [1:0]   INC_C    = 2'(PONTOS_C);

    logic borda_a_c, borda_b_c, borda_c_c;
    logic evento_c;
    logic sel_ok_c;

    logic [PW-1:0] score_q [N_TIMES];
    logic [PW-1:0] score_d [N_TIMES];
    logic          valido_q, valido_d;
    logic          erro_q, erro_d;
    logic          buzina_q, buzina_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0]    inc;
    logic [PW-1:0] cur;
    logic [PW-1:0] nxt;
    logic [PW:0]   soma;

    detector_borda u_borda_a (.clk(clk), .rst_n(rst_n), .btn(btn_a), .borda_c(borda_a_c));
    detector_borda u_borda_b (.clk(clk), .rst_n(rst_n), .btn(btn_b), .borda_c(borda_b_c));
    detector_borda u_borda_c (.clk(clk), .rst_n(rst_n), .btn(btn_c), .borda_c(borda_c_c));

`ifdef PLACAR_DESFAZER_EN
    logic          borda_d_c;
    logic          undo_ok_q, undo_ok_d;
    logic [TW-1:0] undo_team_q, undo_team_d;
    logic [PW-1:0] undo_val_q, undo_val_d;

    detector_borda u_borda_d (.clk(clk), .rst_n(rst_n), .btn(btn_desfazer), .borda_c(borda_d_c));
`endif

    assign evento_c = borda_a_c | borda_b_c | borda_c_c;
    assign sel_ok_c = ({1'b0, time_sel} < (TW+1)'(N_TIMES));

    // Score update, status pulses and buzzer countdown for the current cycle.
    always_comb begin
        score_d  = score_q;
        valido_d = 1'b0;
        erro_d   = 1'b0;
        cnt_d    = cnt_q;
        buzina_d = 1'b0;
        cur      = '0;
        nxt      = '0;
        soma     = '0;
`ifdef PLACAR_DESFAZER_EN
        undo_ok_d   = undo_ok_q;
        undo_team_d = undo_team_q;
        undo_val_d  = undo_val_q;
`endif

        // Highest-valued simultaneous edge wins.
        if (borda_c_c)      inc = INC_C;
        else if (borda_b_c) inc = INC_B;
        else if (borda_a_c) inc = INC_A;
        else                inc = 2'd0;

        for (int unsigned i = 0; i < N_TIMES; i++) begin
            if (TW'(i) == time_sel) cur = score_q[i];
        end

        if (zerar) begin
            for (int unsigned i = 0; i < N_TIMES; i++) score_d[i] = '0;
            valido_d = 1'b1;
`ifdef PLACAR_DESFAZER_EN
            undo_ok_d = 1'b0;
        end else if (borda_d_c) begin
            if (undo_ok_q) begin
                for (int unsigned i = 0; i < N_TIMES; i++) begin
                    if (TW'(i) == undo_team_q) score_d[i] = undo_val_q;
                end
                valido_d  = 1'b1;
                undo_ok_d = 1'b0;
            end else begin
                erro_d = 1'b1;
            end
`endif
        end else if (evento_c) begin
            if (!sel_ok_c) begin
                erro_d = 1'b1;
            end else begin
                if (!modo_sub) begin
                    soma = (PW+1)'(cur) + (PW+1)'(inc);
                    if (soma <= MAX_EXT) begin
                        nxt      = soma[PW-1:0];
                        valido_d = 1'b1;
                    end else begin
                        nxt      = MAX_EXT[PW-1:0];
                        erro_d   = 1'b1;
                        valido_d = (cur != nxt);
                    end
                end else if (PW'(inc) <= cur) begin
                    nxt      = cur - PW'(inc);
                    valido_d = 1'b1;
                end else begin
                    nxt    = cur;
                    erro_d = 1'b1;
                end
                for (int unsigned i = 0; i < N_TIMES; i++) begin
                    if (TW'(i) == time_sel) score_d[i] = nxt;
                end
`ifdef PLACAR_DESFAZER_EN
                if (valido_d) begin
                    undo_ok_d   = 1'b1;
                    undo_team_d = time_sel;
                    undo_val_d  = cur;
                end
`endif
            end
        end

        // Every error (re)loads the buzzer; otherwise count down to zero.
        if (erro_d)            cnt_d = BUZ_LOAD;
        else if (cnt_q != '0)  cnt_d = cnt_q - CW'(1);
        buzina_d = (cnt_d != '0);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q  <= '{default: '0};
            valido_q <= 1'b0;
            erro_q   <= 1'b0;
            buzina_q <= 1'b0;
            cnt_q    <= '0;
`ifdef PLACAR_DESFAZER_EN
            undo_ok_q   <= 1'b0;
            undo_team_q <= '0;
            undo_val_q  <= '0;
`endif
        end else begin
            score_q  <= score_d;
            valido_q <= valido_d;
            erro_q   <= erro_d;
            buzina_q <= buzina_d;
            cnt_q    <= cnt_d;
`ifdef PLACAR_DESFAZER_EN
            undo_ok_q   <= undo_ok_d;
            undo_team_q <= undo_team_d;
            undo_val_q  <= undo_val_d;
`endif
        end
    end

    // Flatten scores onto the display bus.
    for (genvar g = 0; g < N_TIMES; g++) begin : g_flat
        assign pontos[g*PW +: PW] = score_q[g];
    end

    assign valido = valido_q;
    assign erro   = erro_q;
    assign buzina = buzina_q;

endmodule

// File: tb/tb_placar_acumulador.sv
// Self-checking bench for placar_acumulador with a behavioural score model.
module tb_placar_acumulador;

    localparam int N    = 3;
    localparam int PW   = 7;
    localparam int MAXP = 99;
    localparam int BUZ  = 8;
    localparam int VW   = N*PW + 3;
`ifdef PLACAR_DESFAZER_EN
    localparam bit DESF = 1'b1;
`else
    localparam bit DESF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_a = 1'b0, btn_b = 1'b0, btn_c = 1'b0;
`ifdef PLACAR_DESFAZER_EN
    logic          btn_desfazer = 1'b0;
`endif
    logic          modo_sub = 1'b0;
    logic [1:0]    time_sel = 2'd0;
    logic          zerar = 1'b0;
    logic [N*PW-1:0] pontos;
    logic          valido, erro, buzina;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int model [N];
    int last_err = 0;
    bit err_seen = 1'b0;
    bit undo_ok = 1'b0;
    int undo_team = 0;
    int undo_val = 0;

    placar_acumulador #(
        .N_TIMES(N), .PW(PW), .MAX_PONTOS(MAXP), .BUZ_CICLOS(BUZ)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_a(btn_a),
        .btn_b(btn_b),
        .btn_c(btn_c),
`ifdef PLACAR_DESFAZER_EN
        .btn_desfazer(btn_desfazer),
`endif
        .modo_sub(modo_sub),
        .time_sel(time_sel),
        .zerar(zerar),
        .pontos(pontos),
        .valido(valido),
        .erro(erro),
        .buzina(buzina)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N*PW-1:0] model_vec();
        logic [N*PW-1:0] r;
        for (int i = 0; i < N; i++) r[i*PW +: PW] = PW'(model[i]);
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) model[i] = 0;
        err_seen = 1'b0;
        undo_ok  = 1'b0;
    endtask

    // Applies one operation to the model; called at the sample point after it commits.
    task automatic model_step(input logic [3:0] b, input logic sub, input logic [1:0] sel,
                              input logic z, output logic [VW-1:0] exp);
        bit v, e, bz;
        int inc, old;
        v = 0; e = 0;
        if (z) begin
            for (int i = 0; i < N; i++) model[i] = 0;
            v = 1; undo_ok = 0;
        end else if (DESF && b[3]) begin
            if (undo_ok) begin
                model[undo_team] = undo_val; v = 1; undo_ok = 0;
            end else e = 1;
        end else if (b[2:0] != 3'b000) begin
            inc = b[2] ? 3 : (b[1] ? 2 : 1);
            if (int'(sel) >= N) e = 1;
            else begin
                old = model[sel];
                if (!sub) begin
                    if (old + inc <= MAXP) begin model[sel] = old + inc; v = 1; end
                    else begin model[sel] = MAXP; e = 1; v = (old != MAXP); end
                end else if (inc <= old) begin
                    model[sel] = old - inc; v = 1;
                end else e = 1;
                if (v) begin undo_ok = 1; undo_team = int'(sel); undo_val = old; end
            end
        end
        if (e) begin err_seen = 1; last_err = cyc; end
        bz = err_seen && (cyc - last_err < BUZ);
        exp = {model_vec(), v, e, bz};
    endtask

    // Drives one button operation and returns observed/expected state after commit.
    task automatic press(input logic [3:0] b, input logic sub, input logic [1:0] sel,
                         input logic z, input int hold,
                         output logic [VW-1:0] got, output logic [VW-1:0] exp, output bit quiet);
        @(negedge clk);
        btn_a = b[0]; btn_b = b[1]; btn_c = b[2];
`ifdef PLACAR_DESFAZER_EN
        btn_desfazer = b[3];
`endif
        modo_sub = sub; time_sel = sel;
        quiet = 1'b1;
        @(negedge clk);
        quiet &= (valido === 1'b0 && erro === 1'b0 && pontos === model_vec());
        @(negedge clk);
        quiet &= (valido === 1'b0 && erro === 1'b0 && pontos === model_vec());
        zerar = z;
        @(negedge clk);
        zerar = 1'b0;
        model_step(b, sub, sel, z, exp);
        got = {pontos, valido, erro, buzina};
        repeat (hold) begin
            @(negedge clk);
            quiet &= (valido === 1'b0 && erro === 1'b0 && pontos === model_vec());
        end
        btn_a = 0; btn_b = 0; btn_c = 0;
`ifdef PLACAR_DESFAZER_EN
        btn_desfazer = 0;
`endif
        repeat (3) begin
            @(negedge clk);
            quiet &= (valido === 1'b0 && erro === 1'b0 && pontos === model_vec());
        end
    endtask

    task automatic load_team(input int t, input int v);
        logic [VW-1:0] g, e;
        bit q;
        int d;
        while (model[t] < v) begin
            d = v - model[t];
            press(d >= 3 ? 4'b0100 : (d == 2 ? 4'b0010 : 4'b0001), 1'b0, 2'(t), 1'b0, 0, g, e, q);
        end
    endtask

    task automatic clear_all();
        logic [VW-1:0] g, e;
        bit q;
        press(4'b0000, 1'b0, 2'd0, 1'b1, 0, g, e, q);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({pontos, valido, erro, buzina} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", {pontos, valido, erro, buzina});
        end
        rst_n = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        checks++;
        if ({pontos, valido, erro, buzina} !== '0) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=0", {pontos, valido, erro, buzina});
        end
    endtask

    task automatic test_held_button();
        logic [VW-1:0] g, e;
        bit q;
        press(4'b0010, 1'b0, 2'd0, 1'b0, 8, g, e, q);
        checks++;
        if (g !== e) begin failures++; $display("FAIL held_state got=%h exp=%h", g, e); end
        checks++;
        if (g[VW-1 -: PW] !== 7'd0 || g[3 +: PW] !== 7'd2) begin
            failures++; $display("FAIL held_team0 got=%0d exp=2", g[3 +: PW]);
        end
        checks++;
        if (!q) begin failures++; $display("FAIL held_single_pulse got=extra exp=one"); end
    endtask

    task automatic test_saturation();
        logic [VW-1:0] e;
        int n;
        load_team(1, 97);
        @(negedge clk);
        btn_c = 1; modo_sub = 0; time_sel = 2'd1;
        @(negedge clk); btn_c = 0;
        @(negedge clk);
        @(negedge clk);
        model_step(4'b0100, 1'b0, 2'd1, 1'b0, e);
        checks++;
        if ({pontos, valido, erro, buzina} !== e) begin
            failures++; $display("FAIL sat_state got=%h exp=%h", {pontos, valido, erro, buzina}, e);
        end
        checks++;
        if (pontos[PW +: PW] !== 7'(MAXP) || erro !== 1'b1) begin
            failures++; $display("FAIL sat_value got=%0d/%b exp=%0d/1", pontos[PW +: PW], erro, MAXP);
        end
        n = 0;
        for (int t = 0; t < 30; t++) begin
            if (t > 0) @(negedge clk);
            if (buzina !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != BUZ) begin failures++; $display("FAIL sat_buzina_len got=%0d exp=%0d", n, BUZ); end
    endtask

    task automatic test_sub_retrigger();
        logic [VW-1:0] e;
        int n;
        clear_all();
        load_team(0, 1);
        @(negedge clk);
        btn_b = 1; modo_sub = 1; time_sel = 2'd0;
        @(negedge clk); btn_b = 0;
        @(negedge clk);
        n = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (t == 0) begin
                model_step(4'b0010, 1'b1, 2'd0, 1'b0, e);
                checks++;
                if ({pontos, valido, erro, buzina} !== e) begin
                    failures++; $display("FAIL sub_reject got=%h exp=%h", {pontos, valido, erro, buzina}, e);
                end
                btn_b = 1;
            end else if (t == 1) begin
                btn_b = 0;
                checks++;
                if (erro !== 1'b0) begin failures++; $display("FAIL sub_erro_pulse got=%b exp=0", erro); end
            end else if (t == 3) begin
                model_step(4'b0010, 1'b1, 2'd0, 1'b0, e);
                checks++;
                if ({pontos, valido, erro, buzina} !== e) begin
                    failures++; $display("FAIL sub_second_err got=%h exp=%h", {pontos, valido, erro, buzina}, e);
                end
            end
            if (buzina !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != 3 + BUZ) begin failures++; $display("FAIL retrigger_len got=%0d exp=%0d", n, 3 + BUZ); end
    endtask

    task automatic test_simultaneous_and_zerar();
        logic [VW-1:0] g, e;
        bit q;
        clear_all();
        load_team(0, 5);
        press(4'b0101, 1'b0, 2'd0, 1'b0, 0, g, e, q);
        checks++;
        if (g !== e || g[3 +: PW] !== 7'd8) begin
            failures++; $display("FAIL simult_ac got=%h exp=%h", g, e);
        end
        load_team(2, 6);
        press(4'b0001, 1'b0, 2'd0, 1'b1, 0, g, e, q);
        checks++;
        if (g !== e) begin failures++; $display("FAIL zerar_btn got=%h exp=%h", g, e); end
        checks++;
        if (g[VW-1:3] !== '0 || g[1] !== 1'b0 || g[2] !== 1'b1) begin
            failures++; $display("FAIL zerar_clear got=%h exp=valido_only", g);
        end
    endtask

    task automatic test_bad_sel_and_reset();
        logic [VW-1:0] g, e;
        bit q;
        bit exp_bz;
        load_team(2, 4);
        press(4'b0001, 1'b0, 2'd3, 1'b0, 0, g, e, q);
        checks++;
        if (g !== e || g[1] !== 1'b1) begin failures++; $display("FAIL bad_sel got=%h exp=%h", g, e); end
        exp_bz = err_seen && (cyc - last_err < BUZ);
        checks++;
        if (buzina !== exp_bz) begin failures++; $display("FAIL bad_sel_buzina got=%b exp=%b", buzina, exp_bz); end
        btn_b = 1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pontos, valido, erro, buzina} !== '0) begin
            failures++; $display("FAIL async_reset got=%h exp=0", {pontos, valido, erro, buzina});
        end
        model_clear();
        btn_b = 0;
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({pontos, valido, erro, buzina} !== '0) begin
            failures++; $display("FAIL reset_pending_edge got=%h exp=0", {pontos, valido, erro, buzina});
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] g, e;
        bit q;
        logic [3:0] b;
        for (int it = 0; it < 40; it++) begin
            b = {1'b0, 3'($urandom_range(0, 7))};
            press(b, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 9) == 0), 0, g, e, q);
            checks++;
            if (g !== e) begin failures++; $display("FAIL random_%0d got=%h exp=%h", it, g, e); end
            checks++;
            if (!q) begin failures++; $display("FAIL random_quiet_%0d got=extra exp=none", it); end
        end
    endtask

`ifdef PLACAR_DESFAZER_EN
    task automatic test_desfazer();
        logic [VW-1:0] g, e;
        bit q;
        clear_all();
        load_team(0, 4);
        press(4'b0100, 1'b0, 2'd0, 1'b0, 0, g, e, q);
        checks++;
        if (g !== e || g[3 +: PW] !== 7'd7) begin failures++; $display("FAIL undo_add got=%h exp=%h", g, e); end
        press(4'b1000, 1'b0, 2'd0, 1'b0, 0, g, e, q);
        checks++;
        if (g !== e || g[3 +: PW] !== 7'd4) begin failures++; $display("FAIL undo_restore got=%h exp=%h", g, e); end
        press(4'b1010, 1'b0, 2'd0, 1'b0, 0, g, e, q);
        checks++;
        if (g !== e || g[1] !== 1'b1 || g[3 +: PW] !== 7'd4) begin
            failures++; $display("FAIL undo_empty got=%h exp=%h", g, e);
        end
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_held_button();
        test_saturation();
        test_sub_retrigger();
        test_simultaneous_and_zerar();
        test_bad_sel_and_reset();
        test_random();
`ifdef PLACAR_DESFAZER_EN
        test_desfazer();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/placar_acumulador.md
Name: placar_acumulador

Overview:
- Clocked successor to the combinational button/adder/display scoreboard path.
- Holds the scores of N_TIMES teams in registers.
- Turns debounced button presses (1/2/3 points) into single add or subtract operations on the selected team.
- Saturates at MAX_PONTOS, refuses subtraction below zero, and drives a timed buzzer on any rejected or clipped operation.
- Feeds the existing 7-segment decoder through a flat score bus.

Parameters:
- N_TIMES, 2, number of teams (≥2).
- PW, 7, width of each score register in bits.
- MAX_PONTOS, 99, saturation ceiling; must be < 2**PW.
- BUZ_CICLOS, 25000000, buzzer-on duration in clk cycles (≥1).
- TW (localparam), $clog2(N_TIMES), team-select width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_a  in  1  raw +1/−1 button, asynchronous
- btn_b  in  1  raw +2/−2 button, asynchronous
- btn_c  in  1  raw +3/−3 button, asynchronous
- modo_sub  in  1  0 = add, 1 = subtract; sampled in the edge cycle
- time_sel  in  TW  target team index
- zerar  in  1  synchronous clear of all scores, level-sensitive
- pontos  out  N_TIMES*PW  team i occupies bits [i*PW +: PW]
- valido  out  1  one-cycle pulse when a score register changes
- erro  out  1  one-cycle pulse on a rejected or clipped operation
- buzina  out  1  held high for BUZ_CICLOS cycles after each erro

Behaviour:
- Reset: pontos = 0 for all teams; valido = 0; erro = 0; buzina = 0; buzzer counter = 0; synchronizer and edge flops = 0.
- Input conditioning, per button:
  - 2-FF synchronizer, then rising-edge detect (sync & ~sync_d).
  - A button held high produces exactly one event.
- Increment selection:
  - inc = 3 if edge C, else 2 if edge B, else 1 if edge A.
  - Simultaneous edges: highest value wins, others dropped; no error.
- Latency:
  - A raw button rising before clk edge k is registered at k (sync1) and k+1 (sync2).
  - Edge is detected in cycle k+1.
  - pontos, valido and erro update at clk edge k+2.
- Add:
  - If score+inc ≤ MAX_PONTOS: score += inc, valido = 1.
  - Otherwise: score = MAX_PONTOS, erro = 1. valido = 1 only if the value changed.
  - Sum is computed PW+1 bits wide.
- Subtract:
  - If inc ≤ score: score −= inc, valido = 1.
  - Otherwise: score unchanged, erro = 1, valido = 0.
- time_sel ≥ N_TIMES when an event fires: no change, erro = 1.
- zerar:
  - All scores go to 0 at the next edge; valido = 1.
  - Any button event in the same cycle is discarded with no erro.
  - zerar does not affect buzina.
- Buzzer:
  - erro loads the counter with BUZ_CICLOS.
  - buzina = (counter ≠ 0); counter decrements to 0.
  - A new erro while active reloads the counter (retrigger).
- Reset mid-operation: asynchronous clear of everything, including a pending edge and a running buzzer.
- Operation order per cycle: zerar > button event. At most one score changes per cycle.

Optional Feature:
- Macro PLACAR_DESFAZER_EN adds input btn_desfazer (1 bit, synchronized and edge-detected like the others).
- With the macro:
  - Every committed (valido) button operation saves {team, previous score} in a one-deep undo slot and sets undo_ok.
  - A desfazer edge with undo_ok restores that score, pulses valido, and clears undo_ok.
  - A desfazer edge without undo_ok pulses erro.
  - zerar clears undo_ok.
  - A simultaneous score-button edge is ignored in favour of desfazer.
- Without the macro: no port and no undo logic.

Decomposition:
- Package placar_pkg holds:
  - constants PONTOS_A = 1, PONTOS_B = 2, PONTOS_C = 3;
  - default MAX_PONTOS and BUZ_CICLOS;
  - function clog2 helper.
- One sub-module, detector_borda: 2-FF synchronizer plus rising-edge pulse, instantiated once per button.

Test Plan:
- Reset, then btn_b high for 10 cycles, modo_sub = 0, time_sel = 0 -> team 0 = 2 exactly 2 edges after the first sample; a single valido pulse.
- Team 1 = 97, btn_c add -> team 1 = 99 (MAX_PONTOS), erro pulse, buzina high for exactly BUZ_CICLOS (bench uses 8).
- Team 0 = 1, modo_sub = 1, btn_b -> team 0 stays 1, erro = 1, valido = 0; a second erro 3 cycles later extends buzina to 3+8 cycles total.
- btn_a and btn_c rising in the same cycle, team 0 = 5 -> team 0 = 8; zerar asserted together with btn_a -> all teams 0, no erro.
- time_sel = 3 with N_TIMES = 3 -> no change, erro; rst_n dropped while buzina active -> buzina and all pontos 0 immediately.
- With PLACAR_DESFAZER_EN: team 0 = 4, add 3 -> 7, desfazer -> 4; second desfazer -> erro, score unchanged.
